uart_rx: RTL
============

Name: uart_rx

Overview:
Serial UART receiver, 8N1 framing, LSB first, one start bit and one stop bit.
- Runs at the same `clocks_per_bit` rate as the transmit side.
- Recovers bytes from the asynchronous serial line and presents each byte with a 1-cycle valid pulse.
- Flags framing errors.
- Sits at the chip pin boundary and feeds the host/debug byte stream.

Parameters:
- `clocks_per_bit`, default 4: clk cycles per serial bit. Legal range >= 2.
- Half-bit delay is floor(`clocks_per_bit`/2).

Ports:
- `clk`, input, 1: system clock. All logic on posedge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `in_rx`, input, 1: serial line, idle high. Asynchronous to `clk`.
- `out_data`, output, 8: last correctly received byte. Held until the next good byte.
- `out_valid`, output, 1: 1-cycle pulse; `out_data` is new this cycle.
- `out_frame_err`, output, 1: 1-cycle pulse; stop bit sampled low.
- `out_busy`, output, 1: high whenever the FSM is not IDLE.
- `out_parity_err`, output, 1: 1-cycle pulse on parity mismatch. Tied 0 without `UART_RX_PARITY_EN`.

Behaviour:
- Reset values:
  - 2-flop synchronizer flops = 1; state = IDLE.
  - `cycle_count` = 0; `bit_count` = 0; shift register = 0.
  - `out_data` = 8'h00; `out_valid`, `out_frame_err`, `out_parity_err`, `out_busy` = 0.
- Input path: `in_rx` passes through 2 flops (`sync1` -> `sync2`). All FSM decisions use `sync2` only.
- `out_valid`, `out_frame_err`, `out_parity_err` default to 0 every cycle. They are set only on the cycle described below.
- `cycle_count` width: $clog2(`clocks_per_bit`). `bit_count` width: 4.
- Sample rule: in START, DATA, STOP and PARITY, decrement `cycle_count` when nonzero. Sample `sync2` only on a cycle where `cycle_count` == 0.
- IDLE:
  - If `sync2` == 0: go to START, `cycle_count` = `clocks_per_bit`/2 - 1.
  - Otherwise stay in IDLE.
- START, at sample:
  - `sync2` == 0: go to DATA, `cycle_count` = `clocks_per_bit` - 1, `bit_count` = 8.
  - `sync2` == 1 (glitch): return to IDLE. No pulse.
- DATA, at sample:
  - shift = {`sync2`, shift[7:1]}; `bit_count` - 1; `cycle_count` reloads to `clocks_per_bit` - 1.
  - When `bit_count` was 1, go to STOP (or PARITY if enabled).
- STOP, at sample:
  - `sync2` == 1: `out_data` <= shift, `out_valid` <= 1, go to IDLE.
  - `sync2` == 0: `out_frame_err` <= 1, `out_data` unchanged, go to BREAK.
- BREAK: wait until `sync2` == 1, then go to IDLE. A held-low line never produces repeated frames.
- Latency: with the first clock edge seeing `in_rx` low counted as edge 1, `out_valid` goes high after edge 3 + `clocks_per_bit`/2 + 9*`clocks_per_bit`. For `clocks_per_bit`=4 this is edge 41.
- Back-to-back frames: a start bit arriving directly after the stop-bit sample is accepted. IDLE reacts on the next cycle.
- Async reset mid-frame: abort immediately with no pulse. If the line is still low after reset, IDLE treats it as a new start bit.
- `out_busy` is combinational from state: high in START, DATA, PARITY, STOP and BREAK.

Optional Feature:
`UART_RX_PARITY_EN`
- Defined:
  - A PARITY state is inserted between DATA and STOP, one bit period long.
  - Even parity: the expected bit is the XOR of the 8 data bits.
  - On a mismatch, a flag is recorded. At a good stop bit, `out_parity_err` pulses instead of `out_valid`, and `out_data` is not updated.
  - Frame length becomes 11 bits. Latency gains `clocks_per_bit`.
- Undefined:
  - No PARITY state; 10-bit frame.
  - `out_parity_err` is constant 0.

Test Plan:
- Reset with `in_rx`=1, hold 20 cycles: all outputs 0, `out_busy`=0, no pulses.
- `clocks_per_bit`=4, send 8'hA5 as a 10-bit frame at 4 clk/bit: `out_valid` is a single pulse after edge 41 with `out_data`=8'hA5, and `out_busy` falls the same cycle.
- Send 8'h00 then 8'hFF back-to-back with no idle gap: two `out_valid` pulses exactly 40 cycles apart, data 8'h00 then 8'hFF.
- Drive a 1-cycle low glitch on idle `in_rx`: FSM returns to IDLE from START; no `out_valid` and no `out_frame_err`.
- Send 8'h3C with the stop bit low, then hold low for 30 cycles: one `out_frame_err` pulse; `out_data` keeps its prior value; `out_busy` stays high until the line returns high; no further pulses.
- Assert `rst_n`=0 during data bit 4 of 8'h55, then release and send 8'h81: no pulse for the aborted frame; the next `out_valid` carries 8'h81. With `UART_RX_PARITY_EN`, 8'h81 with parity bit 1 gives `out_parity_err`; with parity bit 0 it gives `out_valid`.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 2-flop input synchronizer and framing-error detection.
// Define UART_RX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_rx #(
  parameter int clocks_per_bit = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_frame_err,
  output logic       out_busy,
  output logic       out_parity_err
);

  localparam int cw = $clog2(clocks_per_bit);
  localparam logic [cw-1:0] full_reload = cw'(clocks_per_bit - 1);
  localparam logic [cw-1:0] half_reload = cw'(clocks_per_bit / 2 - 1);

`ifdef UART_RX_PARITY_EN
  localparam bit parity_en = 1'b1;
`else
  localparam bit parity_en = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t          state, state_n;
  logic            sync1, sync2;
  logic [cw-1:0]   cycle_count, cycle_count_n;
  logic [3:0]      bit_count, bit_count_n;
  logic [7:0]      shift, shift_n;
  logic [7:0]      data_n;
  logic            valid_n, frame_err_n, parity_err_n;
  logic            parity_bad, parity_bad_n;
  logic            sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= in_rx;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cycle_count    <= '0;
      bit_count      <= '0;
      shift          <= '0;
      parity_bad     <= 1'b0;
      out_data       <= 8'h00;
      out_valid      <= 1'b0;
      out_frame_err  <= 1'b0;
      out_parity_err <= 1'b0;
    end else begin
      state          <= state_n;
      cycle_count    <= cycle_count_n;
      bit_count      <= bit_count_n;
      shift          <= shift_n;
      parity_bad     <= parity_bad_n;
      out_data       <= data_n;
      out_valid      <= valid_n;
      out_frame_err  <= frame_err_n;
      out_parity_err <= parity_err_n;
    end
  end

  assign sample   = (cycle_count == '0);
  assign out_busy = (state != IDLE);

  always_comb begin
    state_n       = state;
    cycle_count_n = cycle_count;
    bit_count_n   = bit_count;
    shift_n       = shift;
    parity_bad_n  = parity_bad;
    data_n        = out_data;
    valid_n       = 1'b0;
    frame_err_n   = 1'b0;
    parity_err_n  = 1'b0;

    // Every timed state counts down to the bit centre before looking at the line.
    if (state != IDLE && state != BREAK && !sample) begin
      cycle_count_n = cycle_count - cw'(1);
    end

    case (state)
      IDLE: begin
        if (!sync2) begin
          state_n       = START;
          cycle_count_n = half_reload;
        end
      end
      START: begin
        if (sample) begin
          if (!sync2) begin
            state_n       = DATA;
            cycle_count_n = full_reload;
            bit_count_n   = 4'd8;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shift_n       = {sync2, shift[7:1]};
          bit_count_n   = bit_count - 4'd1;
          cycle_count_n = full_reload;
          if (bit_count == 4'd1) begin
            state_n = parity_en ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (sample) begin
          parity_bad_n  = sync2 ^ (^shift);
          cycle_count_n = full_reload;
          state_n       = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          if (sync2) begin
            state_n = IDLE;
            if (parity_en && parity_bad) begin
              parity_err_n = 1'b1;
            end else begin
              data_n  = shift;
              valid_n = 1'b1;
            end
          end else begin
            frame_err_n = 1'b1;
            state_n     = BREAK;
          end
        end
      end
      BREAK: begin
        // A line stuck low must return high before another frame can start.
        if (sync2) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
